// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared types for the hazard control pipeline: register numbers, per-stage
// control structs and their bubble values.
package hazard_ctrl_pipe_pkg;

  localparam int RW = 4;

  typedef logic [RW-1:0] regnum_t;

  localparam regnum_t PCREG = regnum_t'(15);

  typedef struct packed {
    regnum_t ra1;
    regnum_t ra2;
    regnum_t wa3;
    logic    regWrite;
    logic    memtoReg;
    logic    pcSrc;
    logic    branch;
  } ctrl_e_t;

  typedef struct packed {
    regnum_t wa3;
    logic    regWrite;
    logic    pcSrc;
  } ctrl_mw_t;

  localparam ctrl_e_t  CTRL_E_BUBBLE  = '0;
  localparam ctrl_mw_t CTRL_MW_BUBBLE = '0;

  // True when a register write targets the PC.
  function automatic logic writes_pc(regnum_t wa3, logic reg_write);
    return reg_write && (wa3 == PCREG);
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_if.sv
// Decode/hazard-unit <-> control pipeline signal bundle. The perf counter
// outputs exist only when HAZ_CTRL_PERFCNT_EN is defined.
interface hazard_ctrl_pipe_if;
  import hazard_ctrl_pipe_pkg::*;

  // Level signals sampled every rising edge; no valid/ready handshake, the
  // hazard unit owns flow control through StallD and FlushE.
  regnum_t RA1D, RA2D, WA3D;
  logic    RegWriteD, MemtoRegD, PCSrcD, BranchD;
  logic    CondExE, StallD, FlushE;

  regnum_t RA1E, RA2E, writeAddressM, WA3W;
  logic    MemtoRegE, Match_12D_E, BranchTakenE;
  logic    regWriteM, regWriteW, PCWrPendingF, PCSrcW;
`ifdef HAZ_CTRL_PERFCNT_EN
  logic [31:0] stallCount, flushCount, branchCount;
`endif

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchD,
    output CondExE, StallD, FlushE,
`ifdef HAZ_CTRL_PERFCNT_EN
    input  stallCount, flushCount, branchCount,
`endif
    input  RA1E, RA2E, MemtoRegE, Match_12D_E, BranchTakenE,
    input  regWriteM, regWriteW, writeAddressM, WA3W, PCWrPendingF, PCSrcW
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchD,
    input  CondExE, StallD, FlushE,
`ifdef HAZ_CTRL_PERFCNT_EN
    output stallCount, flushCount, branchCount,
`endif
    output RA1E, RA2E, MemtoRegE, Match_12D_E, BranchTakenE,
    output regWriteM, regWriteW, writeAddressM, WA3W, PCWrPendingF, PCSrcW
  );

endinterface

// File: rtl/hazard_ctrl_pipe_ctrl_stage_reg.sv
// Struct-wide pipeline register with synchronous reset and bubble load.
module ctrl_stage_reg #(
  parameter type T      = logic,
  parameter T    BUBBLE = T'(0)
) (
  input  logic clk,
  input  logic rst,
  input  logic bubble_i,
  input  T     d_i,
  output T     q_o
);

  T q_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) q_q <= BUBBLE;
    else                 q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Control-side E/M/W tracker feeding the hazard unit. Define
// HAZ_CTRL_PERFCNT_EN to add stall/flush/branch event counters.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
(
  input logic               clk,
  input logic               reset,
  hazard_ctrl_pipe_if.slave bus
);

  ctrl_e_t  e_d, e_q;
  ctrl_mw_t m_d, m_q, w_q;

  always_comb begin
    e_d = '{ra1: bus.RA1D, ra2: bus.RA2D, wa3: bus.WA3D,
            regWrite: bus.RegWriteD, memtoReg: bus.MemtoRegD,
            pcSrc: bus.PCSrcD, branch: bus.BranchD};
    // A failed condition turns the Execute instruction into a bubble in M.
    m_d = '{wa3: e_q.wa3,
            regWrite: e_q.regWrite & bus.CondExE,
            pcSrc: e_q.pcSrc & bus.CondExE};
  end

  // A stalled Decode must not also issue, so stall inserts a bubble into E.
  ctrl_stage_reg #(.T(ctrl_e_t), .BUBBLE(CTRL_E_BUBBLE)) u_stage_e (
    .clk(clk), .rst(reset), .bubble_i(bus.StallD | bus.FlushE),
    .d_i(e_d), .q_o(e_q)
  );

  ctrl_stage_reg #(.T(ctrl_mw_t), .BUBBLE(CTRL_MW_BUBBLE)) u_stage_m (
    .clk(clk), .rst(reset), .bubble_i(1'b0), .d_i(m_d), .q_o(m_q)
  );

  ctrl_stage_reg #(.T(ctrl_mw_t), .BUBBLE(CTRL_MW_BUBBLE)) u_stage_w (
    .clk(clk), .rst(reset), .bubble_i(1'b0), .d_i(m_q), .q_o(w_q)
  );

  assign bus.RA1E          = e_q.ra1;
  assign bus.RA2E          = e_q.ra2;
  assign bus.MemtoRegE     = e_q.memtoReg;
  assign bus.Match_12D_E   = e_q.regWrite &
                             ((bus.RA1D == e_q.wa3) | (bus.RA2D == e_q.wa3));
  assign bus.BranchTakenE  = e_q.branch & bus.CondExE;
  assign bus.regWriteM     = m_q.regWrite;
  assign bus.writeAddressM = m_q.wa3;
  assign bus.regWriteW     = w_q.regWrite;
  assign bus.WA3W          = w_q.wa3;
  assign bus.PCSrcW        = w_q.pcSrc;
  // Uses PCSrcE before the condition check: may over-stall, never under-stall.
  assign bus.PCWrPendingF  = bus.PCSrcD | e_q.pcSrc | m_q.pcSrc;

`ifdef HAZ_CTRL_PERFCNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, branch_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_q  + 32'(bus.StallD);
      flush_cnt_q  <= flush_cnt_q  + 32'(bus.FlushE);
      branch_cnt_q <= branch_cnt_q + 32'(bus.BranchTakenE);
    end
  end

  assign bus.stallCount  = stall_cnt_q;
  assign bus.flushCount  = flush_cnt_q;
  assign bus.branchCount = branch_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Self-checking bench for hazard_ctrl_pipe: directed scenarios plus a random
// run scored against a queue of expected M/W contents.
module tb_hazard_ctrl_pipe;
  import hazard_ctrl_pipe_pkg::*;

  localparam int W = 6;  // {regWrite, pcSrc, wa3[3:0]}

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_pipe_if bus ();

  hazard_ctrl_pipe dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_d(input regnum_t ra1, input regnum_t ra2, input regnum_t wa3,
                         input logic rw, input logic mr, input logic pcs, input logic br);
    bus.RA1D = ra1; bus.RA2D = ra2; bus.WA3D = wa3;
    bus.RegWriteD = rw; bus.MemtoRegD = mr; bus.PCSrcD = pcs; bus.BranchD = br;
  endtask

  task automatic drive_idle();
    drive_d('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.StallD = 1'b0; bus.FlushE = 1'b0; bus.CondExE = 1'b1;
  endtask

  task automatic idle(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] outs;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      outs = {bus.RA1E, bus.RA2E, bus.writeAddressM, bus.WA3W, bus.MemtoRegE,
              bus.Match_12D_E, bus.BranchTakenE, bus.regWriteM, bus.regWriteW,
              bus.PCWrPendingF, bus.PCSrcW, 5'b0};
      checks++;
      if (outs !== 32'h0) begin
        errors++; $display("FAIL reset_idle_outputs cycle=%0d got=%h exp=0", c, outs);
      end
      step();
    end
`ifdef HAZ_CTRL_PERFCNT_EN
    checks++;
    if ({bus.stallCount, bus.flushCount, bus.branchCount} !== 96'h0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                         bus.stallCount, bus.flushCount, bus.branchCount);
    end
`endif
  endtask

  task automatic test_load_use();
    idle(3);
    drive_d(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);  // LDR R3
    step();
    drive_d(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // ADD R4, R3
    #1;
    checks++;
    if (bus.MemtoRegE !== 1'b1) begin
      errors++; $display("FAIL load_use_memtoregE got=%0b exp=1", bus.MemtoRegE);
    end
    checks++;
    if (bus.Match_12D_E !== 1'b1) begin
      errors++; $display("FAIL load_use_match got=%0b exp=1", bus.Match_12D_E);
    end
    bus.StallD = 1'b1; bus.FlushE = 1'b1;
    step();
    #1;
    checks++;
    if (bus.MemtoRegE !== 1'b0 || bus.RA1E !== 4'd0 || bus.Match_12D_E !== 1'b0) begin
      errors++; $display("FAIL load_use_bubbleE got memtoreg=%0b ra1=%0d match=%0b exp=0/0/0",
                         bus.MemtoRegE, bus.RA1E, bus.Match_12D_E);
    end
    checks++;
    if (bus.regWriteM !== 1'b1 || bus.writeAddressM !== 4'd3) begin
      errors++; $display("FAIL load_use_M got rw=%0b wa=%0d exp=1/3", bus.regWriteM, bus.writeAddressM);
    end
    bus.StallD = 1'b0; bus.FlushE = 1'b0;
    step();
    #1;
    checks++;
    if (bus.RA1E !== 4'd3 || bus.regWriteM !== 1'b0) begin
      errors++; $display("FAIL load_use_reissue got ra1E=%0d rwM=%0b exp=3/0", bus.RA1E, bus.regWriteM);
    end
    checks++;
    if (bus.regWriteW !== 1'b1 || bus.WA3W !== 4'd3) begin
      errors++; $display("FAIL load_use_W got rw=%0b wa=%0d exp=1/3", bus.regWriteW, bus.WA3W);
    end
  endtask

  task automatic test_cond_fail();
    idle(3);
    drive_d(4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);  // ADD R5
    step();
    drive_idle();
    bus.CondExE = 1'b0;
    step();
    bus.CondExE = 1'b1;
    #1;
    checks++;
    if (bus.regWriteM !== 1'b0) begin
      errors++; $display("FAIL cond_fail_M got=%0b exp=0", bus.regWriteM);
    end
    step();
    #1;
    checks++;
    if (bus.regWriteW !== 1'b0) begin
      errors++; $display("FAIL cond_fail_W got=%0b exp=0", bus.regWriteW);
    end
  endtask

  task automatic test_pc_write();
    logic exp_pend [5];
    logic exp_pcw  [5];
    exp_pend = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_pcw  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    idle(3);
    drive_d(4'd0, 4'd0, PCREG, 1'b1, 1'b0, 1'b1, 1'b0);  // MOV PC
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.PCWrPendingF !== exp_pend[c] || bus.PCSrcW !== exp_pcw[c]) begin
        errors++; $display("FAIL pc_write cycle=%0d got pend=%0b pcsrcW=%0b exp=%0b/%0b",
                           c, bus.PCWrPendingF, bus.PCSrcW, exp_pend[c], exp_pcw[c]);
      end
      step();
      drive_idle();
    end
  endtask

  task automatic test_branch();
    idle(3);
    drive_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // B
    #1;
    checks++;
    if (bus.BranchTakenE !== 1'b0) begin
      errors++; $display("FAIL branch_before got=%0b exp=0", bus.BranchTakenE);
    end
    step();
    drive_idle();
    bus.FlushE = 1'b1;
    #1;
    checks++;
    if (bus.BranchTakenE !== 1'b1) begin
      errors++; $display("FAIL branch_taken got=%0b exp=1", bus.BranchTakenE);
    end
    step();
    bus.FlushE = 1'b0;
    #1;
    checks++;
    if (bus.BranchTakenE !== 1'b0) begin
      errors++; $display("FAIL branch_after_flush got=%0b exp=0", bus.BranchTakenE);
    end
  endtask

  task automatic test_reset_mid();
    idle(2);
    bus.StallD = 1'b1;
    step();
    bus.StallD = 1'b0;
    drive_d(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive_d(4'd0, 4'd0, PCREG, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.regWriteM !== 1'b0 || bus.regWriteW !== 1'b0 || bus.PCWrPendingF !== 1'b0) begin
      errors++; $display("FAIL reset_mid got rwM=%0b rwW=%0b pend=%0b exp=0/0/0",
                         bus.regWriteM, bus.regWriteW, bus.PCWrPendingF);
    end
`ifdef HAZ_CTRL_PERFCNT_EN
    checks++;
    if ({bus.stallCount, bus.flushCount, bus.branchCount} !== 96'h0) begin
      errors++; $display("FAIL reset_mid_counters got=%0d/%0d/%0d exp=0/0/0",
                         bus.stallCount, bus.flushCount, bus.branchCount);
    end
`endif
  endtask

  // Random traffic scored against an expected queue of M/W contents.
  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w_exp, m_exp;
    ctrl_e_t      pe;
    logic         exp_match, exp_bt, exp_pend;
    int           n_stall, n_flush, n_branch;
    do_reset();
    pe = '0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    n_stall = 0; n_flush = 0; n_branch = 0;
    for (int c = 0; c < 400; c++) begin
      drive_d(regnum_t'($urandom_range(0, 3)), regnum_t'($urandom_range(0, 3)),
              regnum_t'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0));
      bus.StallD  = ($urandom_range(0, 4) == 0);
      bus.FlushE  = ($urandom_range(0, 5) == 0);
      bus.CondExE = ($urandom_range(0, 3) != 0);
      #1;
      w_exp = exp_q.pop_front();
      m_exp = exp_q[0];
      exp_match = pe.regWrite & ((bus.RA1D == pe.wa3) | (bus.RA2D == pe.wa3));
      exp_bt    = pe.branch & bus.CondExE;
      exp_pend  = bus.PCSrcD | pe.pcSrc | m_exp[4];
      checks++;
      if ({bus.regWriteW, bus.PCSrcW, bus.WA3W} !== w_exp) begin
        errors++; $display("FAIL rand_W cycle=%0d got=%b exp=%b", c,
                           {bus.regWriteW, bus.PCSrcW, bus.WA3W}, w_exp);
      end
      checks++;
      if ({bus.regWriteM, bus.writeAddressM} !== {m_exp[5], m_exp[3:0]}) begin
        errors++; $display("FAIL rand_M cycle=%0d got=%b exp=%b", c,
                           {bus.regWriteM, bus.writeAddressM}, {m_exp[5], m_exp[3:0]});
      end
      checks++;
      if ({bus.RA1E, bus.RA2E, bus.MemtoRegE, bus.Match_12D_E, bus.BranchTakenE, bus.PCWrPendingF}
          !== {pe.ra1, pe.ra2, pe.memtoReg, exp_match, exp_bt, exp_pend}) begin
        errors++; $display("FAIL rand_E cycle=%0d got=%b exp=%b", c,
          {bus.RA1E, bus.RA2E, bus.MemtoRegE, bus.Match_12D_E, bus.BranchTakenE, bus.PCWrPendingF},
          {pe.ra1, pe.ra2, pe.memtoReg, exp_match, exp_bt, exp_pend});
      end
      exp_q.push_back({pe.regWrite & bus.CondExE, pe.pcSrc & bus.CondExE, pe.wa3});
      n_stall  += int'(bus.StallD);
      n_flush  += int'(bus.FlushE);
      n_branch += int'(exp_bt);
      if (bus.StallD || bus.FlushE) pe = '0;
      else pe = '{ra1: bus.RA1D, ra2: bus.RA2D, wa3: bus.WA3D, regWrite: bus.RegWriteD,
                  memtoReg: bus.MemtoRegD, pcSrc: bus.PCSrcD, branch: bus.BranchD};
      step();
    end
`ifdef HAZ_CTRL_PERFCNT_EN
    checks++;
    if (bus.stallCount !== 32'(n_stall) || bus.flushCount !== 32'(n_flush) ||
        bus.branchCount !== 32'(n_branch)) begin
      errors++; $display("FAIL rand_counters got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         bus.stallCount, bus.flushCount, bus.branchCount,
                         n_stall, n_flush, n_branch);
    end
`else
    checks++;
    if (n_stall == 0 || n_flush == 0) begin
      errors++; $display("FAIL rand_coverage got stalls=%0d flushes=%0d exp=nonzero",
                         n_stall, n_flush);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_cond_fail();
    test_pc_write();
    test_branch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Control-side pipeline tracker for the 5-stage ARM core.
- Carries per-instruction hazard-relevant control (register write, load, PC write, branch, destination/source register numbers) from Decode through Execute, Memory and Writeback.
- Honours the stall/flush commands issued by the hazard unit.
- Generates every status input the hazard unit consumes: regWriteM/W, writeAddressM, WA3W, RA1E/RA2E, MemtoRegE, Match_12D_E, PCWrPendingF, PCSrcW, BranchTakenE.

Parameters:
- RW, 4, register-number width (16 architectural registers).
- PCREG, 15, register number treated as the PC.

Ports:
- clk  in  1  single core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RA1D  in  RW  source register 1 of instruction in Decode.
- RA2D  in  RW  source register 2 of instruction in Decode.
- WA3D  in  RW  destination register of instruction in Decode.
- RegWriteD  in  1  Decode instruction writes a register.
- MemtoRegD  in  1  Decode instruction is a load.
- PCSrcD  in  1  Decode instruction writes PC via the register file (WA3D==PCREG with RegWriteD, or load to PC).
- BranchD  in  1  Decode instruction is a B/BL.
- CondExE  in  1  condition check passed for the instruction in Execute.
- StallD  in  1  Decode stall from hazard unit.
- FlushE  in  1  Execute flush from hazard unit.
- RA1E, RA2E  out  RW each  registered source registers in Execute.
- MemtoRegE  out  1  load in Execute.
- Match_12D_E  out  1  Decode source matches Execute destination.
- BranchTakenE  out  1  branch in Execute, condition passed.
- regWriteM, regWriteW  out  1 each  committed register writes in Memory / Writeback.
- writeAddressM, WA3W  out  RW each  destinations in Memory / Writeback.
- PCWrPendingF  out  1  PC write in flight in Decode, Execute or Memory.
- PCSrcW  out  1  PC write committing in Writeback.

Behaviour:
- State: E, M and W control registers.
  - E holds RA1, RA2, WA3, RegWrite, MemtoReg, PCSrc, Branch.
  - M and W hold WA3, RegWrite, PCSrc.
- Reset: all registers clear to 0; every output is 0 the cycle after reset.
  - Match_12D_E is qualified by RegWriteE, so it is also 0.
  - PCWrPendingF equals PCSrcD until new instructions enter.
- E update, each edge:
  - If FlushE or StallD: E loads a bubble (all control bits 0, register fields 0).
  - Otherwise E loads the Decode fields.
  - An instruction held in Decode is never issued twice.
- M update: every edge; never stalls or flushes.
  - RegWriteM = RegWriteE & CondExE.
  - PCSrcM = PCSrcE & CondExE.
  - WA3M = WA3E.
- W update: every edge, M copied to W.
- Latency: a D instruction reaches regWriteM 2 edges after issue and regWriteW 3 edges after issue.
- Combinational outputs:
  - Match_12D_E = RegWriteE & ((RA1D==WA3E) | (RA2D==WA3E)).
  - BranchTakenE = BranchE & CondExE.
  - PCWrPendingF = PCSrcD | PCSrcE | PCSrcM. PCSrcE is taken before the condition check (conservative).
- Boundaries:
  - Condition failure in E: the instruction becomes a bubble in M (no write, no PC write).
  - FlushE and StallD both high: single bubble.
  - Synchronous reset mid-stream discards all in-flight control.
  - Register field compare is exact RW-bit equality; register 0 gets no special treatment.

Optional Feature:
- Macro HAZ_CTRL_PERFCNT_EN.
- When defined, adds three 32-bit outputs:
  - stallCount: increments on each cycle with StallD=1.
  - flushCount: increments on each cycle with FlushE=1.
  - branchCount: increments on each cycle with BranchTakenE=1.
- Counters wrap modulo 2^32 and clear on reset.
- When undefined, no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - typedef regnum_t (RW bits) and PCREG.
  - struct ctrl_e_t {ra1, ra2, wa3, regWrite, memtoReg, pcSrc, branch}.
  - struct ctrl_mw_t {wa3, regWrite, pcSrc}.
  - Bubble constants for both structs.
- One sub-module, ctrl_stage_reg: a struct-wide register with synchronous reset and bubble-load input, instanced for E, M and W.

Test Plan:
- Reset then idle: after reset, with RegWriteD=0 and PCSrcD=0, all outputs are 0 for 5 cycles.
- Load-use: cycle 0 issues LDR R3 (WA3D=3, MemtoRegD=1); cycle 1 Decode has RA1D=3 -> MemtoRegE=1 and Match_12D_E=1. Bench asserts StallD+FlushE -> next cycle E is a bubble and regWriteM=1 with writeAddressM=3.
- Condition fail: ADD R5 issued; in E, CondExE=0 -> regWriteM=0 next cycle and regWriteW=0 the cycle after.
- PC write: MOV PC (PCSrcD=1, WA3D=15) -> PCWrPendingF=1 for 3 consecutive cycles (D, E, M), then PCSrcW=1 for 1 cycle, then 0.
- Branch: BranchD=1 issued, CondExE=1 -> BranchTakenE=1 exactly one cycle; with FlushE held that cycle, E is a bubble next.
- Reset mid-stream: three writes in flight, reset high for 1 cycle -> regWriteM, regWriteW and PCWrPendingF are 0 next cycle. With HAZ_CTRL_PERFCNT_EN defined, counters read 0.
